// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle of the multicycle RV32I core.
// slave: controller (IR, ALU flags, mem_ready in; controls out); master: datapath.
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        Zero;
  logic        cout;
  logic        overflow;
  logic        sign;
  logic        mem_ready;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        AdrSrc;
  logic        IRWrite;
  logic        RegWrite;
  logic        PCWrite;
  logic        MemWrite;
  logic        halted;
  logic [31:0] instret;

  modport master (
    output instr, Zero, cout, overflow, sign, mem_ready,
    input  ImmSrc, ALUControl, ResultSrc, ALUSrcA, ALUSrcB,
    input  AdrSrc, IRWrite, RegWrite, PCWrite, MemWrite,
    input  halted, instret
  );

  modport slave (
    input  instr, Zero, cout, overflow, sign, mem_ready,
    output ImmSrc, ALUControl, ResultSrc, ALUSrcA, ALUSrcB,
    output AdrSrc, IRWrite, RegWrite, PCWrite, MemWrite,
    output halted, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: decodes IR, sequences datapath, counts retires.
// Ports: clk, reset (async, active low), bus (slave modport: IR/flags in, controls out).
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR,
    S_JALRPC, S_LUI, S_AUIPC, S_HALT
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0] op;
  logic [2:0] f3;
  logic       b5;
  assign op = bus.instr[6:0];
  assign f3 = bus.instr[14:12];
  assign b5 = bus.instr[30];

  logic is_ld, is_st, is_r, is_i, is_br;
  logic is_jal, is_jalr, is_lui, is_auipc;
  assign is_ld    = (op == 7'b0000011);
  assign is_st    = (op == 7'b0100011);
  assign is_r     = (op == 7'b0110011);
  assign is_i     = (op == 7'b0010011);
  assign is_br    = (op == 7'b1100011);
  assign is_jal   = (op == 7'b1101111);
  assign is_jalr  = (op == 7'b1100111);
  assign is_lui   = (op == 7'b0110111);
  assign is_auipc = (op == 7'b0010111);

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = !bus.Zero;
      3'b100:  taken = bus.sign ^ bus.overflow;
      3'b101:  taken = !(bus.sign ^ bus.overflow);
      3'b110:  taken = !bus.cout;
      3'b111:  taken = bus.cout;
      default: taken = 1'b0;
    endcase
  end

  // I-type shares the R-type table except funct3=000 (no subi).
  logic [3:0] alu_r, alu_i;
  always_comb begin
    alu_r = ALU_ADD;
    case (f3)
      3'b000: alu_r = b5 ? ALU_SUB : ALU_ADD;
      3'b001: alu_r = ALU_SLL;
      3'b010: alu_r = ALU_SLT;
      3'b011: alu_r = ALU_SLTU;
      3'b100: alu_r = ALU_XOR;
      3'b101: alu_r = b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_r = ALU_OR;
      3'b111: alu_r = ALU_AND;
      default: alu_r = ALU_ADD;
    endcase
    alu_i = (f3 == 3'b000) ? ALU_ADD : alu_r;
  end

  logic [2:0] imm_src;
  logic [3:0] alu_ctl;
  logic [1:0] res_src, src_a, src_b;
  logic       adr_src;
  logic       ir_we, pc_we, rg_we, mm_we;

  always_comb begin
    state_d = state_q;
    imm_src = IMM_I;
    alu_ctl = ALU_ADD;
    res_src = 2'b00;
    src_a   = 2'b00;
    src_b   = 2'b00;
    adr_src = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    rg_we   = 1'b0;
    mm_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b   = 2'b10;
        res_src = 2'b10;
        ir_we   = bus.mem_ready;
        pc_we   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        imm_src = is_jal ? IMM_J : IMM_B;
        unique case (1'b1)
          is_ld, is_st: state_d = S_MEMADR;
          is_r:         state_d = S_EXECR;
          is_i:         state_d = S_EXECI;
          is_br:        state_d = S_BRANCH;
          is_jal:       state_d = S_JAL;
          is_jalr:      state_d = S_JALR;
          is_lui:       state_d = S_LUI;
          is_auipc:     state_d = S_AUIPC;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        imm_src = is_st ? IMM_S : IMM_I;
        state_d = is_st ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src = 2'b01;
        rg_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mm_we   = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_ctl = alu_r;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_ctl = alu_i;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rg_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = 2'b10;
        alu_ctl = ALU_SUB;
        pc_we   = taken;
        state_d = S_FETCH;
      end
      S_JAL: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = S_JALRPC;
      end
      S_JALRPC: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        imm_src = IMM_U;
        res_src = 2'b11;
        rg_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_AUIPC: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        imm_src = IMM_U;
        state_d = S_ALUWB;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Only re-entry into FETCH from another state retires an instruction.
  assign instret_d = (state_q != S_FETCH && state_d == S_FETCH)
                   ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.AdrSrc     = adr_src;
  // FETCH enables follow mem_ready, so mask them while reset is held.
  assign bus.IRWrite    = ir_we & reset;
  assign bus.PCWrite    = pc_we & reset;
  assign bus.RegWrite   = rg_we & reset;
  assign bus.MemWrite   = mm_we & reset;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller.
// Per-instruction expectations are queued by the driver and checked on retire.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  typedef struct {
    int cyc; int rw; int rw_at; int mw; int pw; int iw;
    int c0; int c1; int c2; int c3; int ir;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_ir = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ctl(int imm, int alu, int res,
                             int a, int b, int adr);
    return (imm << 11) | (alu << 7) | (res << 5)
         | (a << 3) | (b << 1) | adr;
  endfunction

  function automatic int alu_of(logic [6:0] op, logic [2:0] f3,
                                logic b5);
    case (f3)
      3'd0: return (op == OP_R && b5) ? 1 : 0;
      3'd1: return 7;
      3'd2: return 5;
      3'd3: return 6;
      3'd4: return 4;
      3'd5: return b5 ? 9 : 8;
      3'd6: return 3;
      default: return 2;
    endcase
  endfunction

  // fl = {Zero, cout, overflow, sign}
  function automatic int br_taken(logic [2:0] f3, logic [3:0] fl);
    case (f3)
      3'd0: return int'(fl[3]);
      3'd1: return int'(!fl[3]);
      3'd4: return int'(fl[0] ^ fl[1]);
      3'd5: return int'(!(fl[0] ^ fl[1]));
      3'd6: return int'(!fl[2]);
      3'd7: return int'(fl[2]);
      default: return 0;
    endcase
  endfunction

  function automatic exp_t model(logic [31:0] ins, int fs, int ms,
                                 logic [3:0] fl, int ir);
    exp_t e;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    int alu = alu_of(op, f3, ins[30]);
    e.iw = 1; e.mw = 0; e.pw = 1; e.rw = 1; e.ir = ir;
    e.c0 = ctl(0, 0, 2, 0, 2, 0);
    e.c1 = ctl(op == OP_JAL ? 3 : 2, 0, 0, 1, 1, 0);
    e.c3 = 0;
    case (op)
      OP_LD: begin
        e.cyc = 5 + ms; e.rw_at = 4 + ms;
        e.c2 = ctl(0, 0, 0, 2, 1, 0); e.c3 = 1;
      end
      OP_ST: begin
        e.cyc = 4 + ms; e.rw = 0; e.rw_at = -1; e.mw = 1 + ms;
        e.c2 = ctl(1, 0, 0, 2, 1, 0); e.c3 = 1;
      end
      OP_R: begin
        e.cyc = 4; e.rw_at = 3; e.c2 = ctl(0, alu, 0, 2, 0, 0);
      end
      OP_I: begin
        e.cyc = 4; e.rw_at = 3; e.c2 = ctl(0, alu, 0, 2, 1, 0);
      end
      OP_BR: begin
        e.cyc = 3; e.rw = 0; e.rw_at = -1;
        e.pw = 1 + br_taken(f3, fl);
        e.c2 = ctl(0, 1, 0, 2, 0, 0); e.c3 = -1;
      end
      OP_JAL: begin
        e.cyc = 4; e.rw_at = 3; e.pw = 2;
        e.c2 = ctl(0, 0, 0, 1, 2, 0);
      end
      OP_JR: begin
        e.cyc = 5; e.rw_at = 4; e.pw = 2;
        e.c2 = ctl(0, 0, 0, 2, 1, 0);
        e.c3 = ctl(0, 0, 0, 1, 2, 0);
      end
      OP_LUI: begin
        e.cyc = 3; e.rw_at = 2;
        e.c2 = ctl(4, 0, 3, 0, 0, 0); e.c3 = -1;
      end
      default: begin
        e.cyc = 4; e.rw_at = 3;
        e.c2 = ctl(4, 0, 0, 1, 1, 0);
      end
    endcase
    e.cyc += fs;
    return e;
  endfunction

  // Drives one instruction; stop >= 0 aborts at that cycle index.
  task automatic run_instr(input logic [31:0] ins, input int fs,
                           input int ms_in, input bit fix,
                           input logic [3:0] ffl, input bit push,
                           input int stop);
    logic [6:0] op = ins[6:0];
    bit   mem = (op == OP_LD || op == OP_ST);
    int   ms = mem ? ms_in : 0;
    logic [3:0] bfl = fix ? ffl : 4'($urandom);
    exp_t e;
    int   total;
    if (push) exp_ir++;
    e = model(ins, fs, ms, bfl, exp_ir);
    total = e.cyc;
    if (push) sb.push_back(e);
    bus.instr = ins;
    for (int c = 0; c < total; c++) begin
      if (stop >= 0 && c >= stop) break;
      if (c < fs) bus.mem_ready = 1'b0;
      else if (c == fs) bus.mem_ready = 1'b1;
      else if (mem && c >= fs + 3) bus.mem_ready = (c >= fs + 3 + ms);
      else bus.mem_ready = 1'($urandom);
      if (fix || c == fs + 2)
        {bus.Zero, bus.cout, bus.overflow, bus.sign} = bfl;
      else
        {bus.Zero, bus.cout, bus.overflow, bus.sign} = 4'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: accumulates per-instruction activity, checks on retire.
  initial begin
    int a_cyc, a_rw, a_rwat, a_mw, a_pw, a_iw, k;
    int a_c[4];
    int last_ir;
    int now;
    exp_t e;
    a_cyc = 0; a_rw = 0; a_rwat = -1; a_mw = 0; a_pw = 0; a_iw = 0;
    k = -1; last_ir = 0;
    for (int i = 0; i < 4; i++) a_c[i] = -1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        a_cyc = 0; a_rw = 0; a_rwat = -1; a_mw = 0; a_pw = 0; a_iw = 0;
        k = -1; last_ir = 0;
        for (int i = 0; i < 4; i++) a_c[i] = -1;
      end else begin
        if (int'(bus.instret) != last_ir) begin
          if (sb.size() == 0) begin
            chk("unexpected_retire", int'(bus.instret), last_ir);
          end else begin
            e = sb.pop_front();
            chk("instret", int'(bus.instret), e.ir);
            chk("cycles", a_cyc, e.cyc);
            chk("regwrite_cnt", a_rw, e.rw);
            chk("regwrite_at", a_rwat, e.rw_at);
            chk("memwrite_cnt", a_mw, e.mw);
            chk("pcwrite_cnt", a_pw, e.pw);
            chk("irwrite_cnt", a_iw, e.iw);
            chk("ctl_fetch", a_c[0], e.c0);
            chk("ctl_decode", a_c[1], e.c1);
            chk("ctl_k2", a_c[2], e.c2);
            chk("ctl_k3", a_c[3], e.c3);
          end
          a_cyc = 0; a_rw = 0; a_rwat = -1; a_mw = 0; a_pw = 0;
          a_iw = 0; k = -1;
          for (int i = 0; i < 4; i++) a_c[i] = -1;
          last_ir = int'(bus.instret);
        end
        if (bus.IRWrite) k = 0;
        else if (k >= 0) k++;
        now = ctl(int'(bus.ImmSrc), int'(bus.ALUControl),
                  int'(bus.ResultSrc), int'(bus.ALUSrcA),
                  int'(bus.ALUSrcB), int'(bus.AdrSrc));
        if (k >= 0 && k < 4) a_c[k] = now;
        a_cyc++;
        if (bus.RegWrite) begin a_rw++; a_rwat = k; end
        if (bus.MemWrite) a_mw++;
        if (bus.PCWrite) a_pw++;
        if (bus.IRWrite) a_iw++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    int w;
    reset = 1'b0;
    bus.instr = 32'h002081b3;
    bus.mem_ready = 1'b1;
    {bus.Zero, bus.cout, bus.overflow, bus.sign} = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enables", int'({bus.RegWrite, bus.MemWrite,
                             bus.PCWrite, bus.IRWrite}), 0);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_instret", int'(bus.instret), 0);
    reset = 1'b1;

    run_instr(32'h002081b3, 0, 0, 0, 4'b0, 1, -1);
    run_instr(32'h0000a283, 0, 2, 0, 4'b0, 1, -1);
    run_instr(32'h0050a023, 0, 3, 0, 4'b0, 1, -1);
    run_instr(32'h00209463, 0, 0, 1, 4'b1000, 1, -1);
    run_instr(32'h0020e463, 0, 0, 1, 4'b0000, 1, -1);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 8))
        0: op = OP_LD;
        1: op = OP_ST;
        2: op = OP_R;
        3: op = OP_I;
        4: op = OP_BR;
        5: op = OP_JAL;
        6: op = OP_JR;
        7: op = OP_LUI;
        default: op = OP_AUI;
      endcase
      ins = $urandom;
      ins[6:0] = op;
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3),
                0, 4'b0, 1, -1);
    end

    ins = $urandom;
    ins[6:0] = 7'b0000000;
    bus.instr = ins;
    bus.mem_ready = 1'b1;
    w = 0;
    while (!bus.halted && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("halt_latency", w, 2);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = 1'($urandom);
      @(negedge clk);
      chk("halt_held", int'(bus.halted), 1);
      chk("halt_enables", int'({bus.RegWrite, bus.MemWrite,
                                bus.PCWrite, bus.IRWrite}), 0);
      @(posedge clk);
      #1;
    end
    chk("sb_drain_halt", sb.size(), 0);
    reset = 1'b0;
    exp_ir = 0;
    #1;
    chk("halt_rst_halted", int'(bus.halted), 0);
    chk("halt_rst_instret", int'(bus.instret), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(32'h0050a023, 0, 5, 0, 4'b0, 0, 5);
    bus.mem_ready = 1'b0;
    #1;
    chk("mw_before_rst", int'(bus.MemWrite), 1);
    reset = 1'b0;
    #1;
    chk("mw_async_drop", int'({bus.RegWrite, bus.MemWrite,
                               bus.PCWrite, bus.IRWrite}), 0);
    chk("abort_instret", int'(bus.instret), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(32'h002081b3, 1, 0, 0, 4'b0, 1, -1);
    bus.mem_ready = 1'b0;
    w = 0;
    while (sb.size() > 0 && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("sb_drain_end", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
